// File: rtl/mem_sram_ctrl.sv
// MEM-stage data-memory controller: one 32-bit load/store becomes two 16-bit SRAM phases (low, then high halfword).
// freeze stalls the pipeline from the cycle the request appears until the DONE cycle, when ready pulses.
module mem_sram_ctrl #(
  parameter int SRAM_AW     = 18,
  parameter int WAIT_CYCLES = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic               freeze,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [2:0] LAST = 3'(WAIT_CYCLES);

  state_t             state;
  logic [2:0]         cnt;
  logic               is_wr;
  logic [SRAM_AW-2:0] addr_q;
  logic [15:0]        wdata_hi;
  logic               req;
  logic               req_wr;
  logic               unused_addr_bits;

  assign req    = mem_read | mem_write;
  // A simultaneous read and write request is serviced as a read only.
  assign req_wr = mem_write & ~mem_read;
  assign freeze = reset & req & (state != DONE);

  assign unused_addr_bits = ^{address[1:0], address[31:SRAM_AW+1]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      is_wr       <= 1'b0;
      addr_q      <= '0;
      wdata_hi    <= 16'h0;
      read_data   <= 32'h0;
      ready       <= 1'b0;
      sram_addr   <= '0;
      sram_dq_out <= 16'h0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b0;
          if (req) begin
            state       <= LOW;
            cnt         <= 3'd0;
            is_wr       <= req_wr;
            addr_q      <= address[SRAM_AW:2];
            wdata_hi    <= write_data[31:16];
            // SRAM bus is set up on the accept edge so the low phase starts with stable outputs.
            sram_addr   <= {address[SRAM_AW:2], 1'b0};
            sram_dq_out <= req_wr ? write_data[15:0] : 16'h0;
            sram_dq_oe  <= req_wr;
            sram_we_n   <= ~req_wr;
          end
        end
        LOW: begin
          if (cnt == LAST) begin
            cnt         <= 3'd0;
            state       <= HIGH;
            sram_addr   <= {addr_q, 1'b1};
            sram_dq_out <= is_wr ? wdata_hi : 16'h0;
            if (!is_wr) read_data[15:0] <= sram_dq_in;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        HIGH: begin
          if (cnt == LAST) begin
            cnt        <= 3'd0;
            state      <= DONE;
            ready      <= 1'b1;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
            if (!is_wr) read_data[31:16] <= sram_dq_in;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        DONE: begin
          ready <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Bench for mem_sram_ctrl: two instances (WAIT_CYCLES=1 and 0) on behavioural SRAMs, checked against a word-level memory model.
// Table vectors, hand-written corner sequences (idle, dropped request, reset mid-store) and random traffic.
module tb_mem_sram_ctrl;

  localparam int AW = 18;

  logic clock = 1'b0;
  logic reset;
  logic rd1, wr1, rd0, wr0;
  logic [31:0] address, write_data;
  logic sel;

  logic [31:0] read_data1, read_data0;
  logic ready1, ready0, freeze1, freeze0;
  logic [AW-1:0] sram_addr1, sram_addr0;
  logic [15:0] dq_out1, dq_out0, dq_in1, dq_in0;
  logic oe1, oe0, we_n1, we_n0;

  logic [15:0] mem1 [0:(1<<AW)-1];
  logic [15:0] mem0 [0:(1<<AW)-1];

  logic [31:0] refm [int];
  logic [31:0] last_rd [2];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vt [8];

  always #5 clock = ~clock;

  mem_sram_ctrl #(.SRAM_AW(AW), .WAIT_CYCLES(1)) dut1 (
    .clock(clock), .reset(reset), .mem_read(rd1), .mem_write(wr1),
    .address(address), .write_data(write_data), .read_data(read_data1),
    .ready(ready1), .freeze(freeze1), .sram_addr(sram_addr1),
    .sram_dq_out(dq_out1), .sram_dq_in(dq_in1), .sram_dq_oe(oe1), .sram_we_n(we_n1)
  );

  mem_sram_ctrl #(.SRAM_AW(AW), .WAIT_CYCLES(0)) dut0 (
    .clock(clock), .reset(reset), .mem_read(rd0), .mem_write(wr0),
    .address(address), .write_data(write_data), .read_data(read_data0),
    .ready(ready0), .freeze(freeze0), .sram_addr(sram_addr0),
    .sram_dq_out(dq_out0), .sram_dq_in(dq_in0), .sram_dq_oe(oe0), .sram_we_n(we_n0)
  );

  assign dq_in1 = mem1[sram_addr1];
  assign dq_in0 = mem0[sram_addr0];

  always @(posedge clock) begin
    if (!we_n1) mem1[sram_addr1] = dq_out1;
    if (!we_n0) mem0[sram_addr0] = dq_out0;
  end

  wire [31:0]   rd_s   = sel ? read_data0 : read_data1;
  wire          rdy_s  = sel ? ready0 : ready1;
  wire          fz_s   = sel ? freeze0 : freeze1;
  wire [AW-1:0] addr_s = sel ? sram_addr0 : sram_addr1;
  wire [15:0]   dq_s   = sel ? dq_out0 : dq_out1;
  wire          oe_s   = sel ? oe0 : oe1;
  wire          we_s   = sel ? we_n0 : we_n1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One access on the selected instance, checked cycle by cycle against the documented timing.
  task automatic access(input logic s, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input int drop_at,
                        input string nm);
    int w, last, fz_c, rdy_c, bus_c, nrdy;
    logic st, act, fz_a, fz_e, rdy_a, rdy_e;
    logic [16:0] word;
    logic [15:0] half;
    logic [35:0] bus_a, bus_e;
    bit fz_bad, rdy_bad, bus_bad;
    w = s ? 0 : 1;
    last = 2 * w + 3;
    st = wr & ~rd;
    word = a[18:2];
    fz_bad = 0; rdy_bad = 0; bus_bad = 0; nrdy = 0;
    fz_c = 0; rdy_c = 0; bus_c = 0;
    for (int c = 0; c <= last; c++) begin
      @(posedge clock); #1;
      if (c == 0) begin
        sel = s; address = a; write_data = wd;
        rd1 = s ? 1'b0 : rd; wr1 = s ? 1'b0 : wr;
        rd0 = s ? rd : 1'b0; wr0 = s ? wr : 1'b0;
      end
      if (c == drop_at) begin rd0 = 0; wr0 = 0; rd1 = 0; wr1 = 0; end
      @(negedge clock);
      if (!fz_bad) begin
        fz_a = fz_s; fz_e = (drop_at < 0 || c < drop_at) && c < last; fz_c = c;
        fz_bad = (fz_a !== fz_e);
      end
      if (!rdy_bad) begin
        rdy_a = rdy_s; rdy_e = (c == last); rdy_c = c;
        rdy_bad = (rdy_a !== rdy_e);
      end
      if (rdy_s === 1'b1) nrdy++;
      if (!bus_bad) begin
        act = (c >= 1) && (c < last);
        half = (c <= w + 1) ? wd[15:0] : wd[31:16];
        bus_e = {!(st && act), st && act, act ? {word, c > w + 1} : 18'h0,
                 (st && act) ? half : 16'h0};
        bus_a = {we_s, oe_s, act ? addr_s : 18'h0, (st && act) ? dq_s : 16'h0};
        bus_c = c;
        bus_bad = (bus_a !== bus_e);
      end
    end
    chk($sformatf("%s freeze c%0d", nm, fz_c), 64'(fz_a), 64'(fz_e));
    chk($sformatf("%s ready c%0d", nm, rdy_c), 64'(rdy_a), 64'(rdy_e));
    chk($sformatf("%s ready_count", nm), 64'(nrdy), 64'd1);
    chk($sformatf("%s sram_bus c%0d", nm, bus_c), 64'(bus_a), 64'(bus_e));
    chk($sformatf("%s read_data", nm), 64'(rd_s), 64'(exp_rd));
  endtask

  // Word-level reference: stores update the word, loads return it, read_data holds the last load.
  task automatic txn(input logic s, input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] wd, input int drop_at, input bit use_exp,
                     input logic [31:0] exp_in, input string nm);
    int key;
    logic [31:0] exp;
    key = (s ? 32'h100000 : 32'h0) + int'(a[18:2]);
    if (use_exp) exp = exp_in;
    else if (rd) exp = refm.exists(key) ? refm[key] : 32'h0;
    else exp = last_rd[int'(s)];
    access(s, rd, wr, a, wd, exp, drop_at, nm);
    if (wr && !rd) refm[key] = wd;
    if (rd) last_rd[int'(s)] = exp;
  endtask

  task automatic idle(input int n, input string nm);
    logic [3:0] v;
    bit bad;
    bad = 0;
    @(posedge clock); #1;
    rd0 = 0; wr0 = 0; rd1 = 0; wr1 = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (!bad) begin
        v = {freeze1 | freeze0, we_n1 & we_n0, oe1 | oe0, ready1 | ready0};
        bad = (v !== 4'b0100);
      end
    end
    chk(nm, 64'(v), 64'h4);
  endtask

  initial begin
    logic [31:0] a, wd;
    int op, wi;
    for (int i = 0; i < (1 << AW); i++) begin mem1[i] = 16'h0; mem0[i] = 16'h0; end
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    sel = 0; address = 32'h10; write_data = 32'h0;
    rd1 = 1; wr1 = 0; rd0 = 0; wr0 = 1;
    reset = 0;

    vt[0] = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000};
    vt[1] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF};
    vt[2] = '{1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0000_0000};
    vt[3] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 32'h0000_0000};
    vt[4] = '{1'b0, 1'b1, 32'h0000_0013, 32'hCAFE_F00D, 32'h0000_0000};
    vt[5] = '{1'b1, 1'b0, 32'h8000_0010, 32'h0000_0000, 32'hCAFE_F00D};
    vt[6] = '{1'b0, 1'b1, 32'h0007_FFFC, 32'h0000_FFFF, 32'hCAFE_F00D};
    vt[7] = '{1'b1, 1'b0, 32'h0007_FFFC, 32'h0000_0000, 32'h0000_FFFF};

    // Reset with requests pending: freeze must stay low and all outputs at reset values.
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset ctl1", 64'({freeze1, ready1, we_n1, oe1}), 64'h2);
    chk("reset ctl0", 64'({freeze0, ready0, we_n0, oe0}), 64'h2);
    chk("reset data1", 64'({read_data1, sram_addr1, dq_out1}), 64'h0);
    chk("reset data0", 64'({read_data0, sram_addr0, dq_out0}), 64'h0);
    rd1 = 0; wr0 = 0;
    @(posedge clock); #1;
    reset = 1;

    // Table vectors, applied back-to-back on the WAIT_CYCLES=1 instance.
    for (int i = 0; i < 8; i++) begin
      txn(1'b0, vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wdata, -1, 1'b1, vt[i].exp_rd,
          $sformatf("vec%0d", i));
      if (i == 0) chk("vec0 sram halves", 64'({mem1[9], mem1[8]}), 64'hDEAD_BEEF);
    end

    // Zero wait cycles: 3-cycle freeze, ready in cycle 3.
    txn(1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0123_4567, -1, 1'b0, 32'h0, "w0_store");
    txn(1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0, -1, 1'b0, 32'h0, "w0_load");
    chk("w0 sram halves", 64'({mem0[33], mem0[32]}), 64'h0123_4567);
    idle(20, "idle quiet");

    // Request dropped mid-access: freeze follows req, access still completes.
    txn(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 2, 1'b0, 32'h0, "drop");
    idle(2, "after drop");

    // Reset during the high phase of a store: low half stays written, high half is not.
    txn(1'b0, 1'b0, 1'b1, 32'h0000_0014, 32'h1111_2222, -1, 1'b0, 32'h0, "rst_pre");
    @(posedge clock); #1;
    sel = 0; address = 32'h14; write_data = 32'hAAAA_BBBB;
    rd1 = 0; wr1 = 1; rd0 = 0; wr0 = 0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst high phase", 64'({we_n1, sram_addr1}), 64'h0000B);
    @(negedge clock);
    reset = 0; wr1 = 0;
    #1;
    chk("rst ctl", 64'({we_n1, oe1, ready1, freeze1}), 64'h8);
    chk("rst data", 64'({read_data1, sram_addr1}), 64'h0);
    @(posedge clock); #1;
    reset = 1;
    refm[5] = 32'h1111_BBBB;
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    txn(1'b0, 1'b1, 1'b0, 32'h0000_0014, 32'h0, -1, 1'b0, 32'h0, "rst_after");

    // Random traffic over 16 words, ignored address bits randomised.
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 2);
      wi = $urandom_range(0, 15);
      wd = $urandom;
      a = ($urandom & 32'hFFF8_0000) | (32'(wi) << 2) | 32'($urandom_range(0, 3));
      txn(1'b0, op != 1, op != 0, a, wd, -1, 1'b0, 32'h0, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 2) == 0) idle(1, $sformatf("rnd_gap%0d", i));
    end

    for (int w = 0; w < 16; w++)
      chk($sformatf("sram word%0d", w), 64'({mem1[2*w+1], mem1[2*w]}),
          64'(refm.exists(w) ? refm[w] : 32'h0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
